// File: rtl/bus_record_formatter.sv
// bus_record_formatter
// Turns captured bus-cycle records into one ASCII text line each
// ("AAAAAAAA DDDDDDDD Rf\r\n") for a UART byte stream. A dump_done pulse
// queues a single "END\r\n" trailer, which is sent once the line in
// progress (if any) has finished. Each byte is handed over on a
// valid/ready handshake, and tx_data/tx_valid come straight from flops.

module bus_record_formatter (
  input  logic        clk,
  input  logic        reset,
  input  logic        rec_valid,
  output logic        rec_ready,
  input  logic [31:0] rec_addr,
  input  logic [31:0] rec_data,
  input  logic        rec_rw,
  input  logic [2:0]  rec_flags,
  input  logic        dump_done,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LINE   = 2'd1;
  localparam logic [1:0] ST_ENDMSG = 2'd2;

  localparam logic [4:0] LINE_LAST = 5'd21;
  localparam logic [4:0] END_LAST  = 5'd4;

  logic [1:0]  state_r;
  logic [4:0]  idx_r;
  logic        pend_r;
  logic        pend_s;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic        rw_r;
  logic [2:0]  flags_r;
  logic        xfer_s;

  // Map a nibble to an uppercase ASCII hex digit.
  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end else begin
      return 8'h37 + {4'h0, n};
    end
  endfunction

  // Pick nibble k of a word, k = 0 being the most significant nibble.
  function automatic logic [3:0] nibble(input logic [31:0] w, input logic [2:0] k);
    logic [31:0] t;
    t = w >> {3'd7 - k, 2'b00};
    return t[3:0];
  endfunction

  // Character i of a record line.
  function automatic logic [7:0] line_char(input logic [31:0] a,
                                           input logic [31:0] d,
                                           input logic        rw,
                                           input logic [2:0]  fl,
                                           input logic [4:0]  i);
    logic [7:0] c;
    logic [2:0] j;
    // data digits sit at indices 9..16; i[2:0]-1 wraps them onto 0..7
    j = i[2:0] - 3'd1;
    if (i <= 5'd7) begin
      c = hex_digit(nibble(a, i[2:0]));
    end else if (i == 5'd8 || i == 5'd17) begin
      c = 8'h20;
    end else if (i <= 5'd16) begin
      c = hex_digit(nibble(d, j));
    end else if (i == 5'd18) begin
      c = rw ? 8'h52 : 8'h57;
    end else if (i == 5'd19) begin
      c = hex_digit({1'b0, fl});
    end else if (i == 5'd20) begin
      c = 8'h0D;
    end else if (i == 5'd21) begin
      c = 8'h0A;
    end else begin
      c = 8'h00;
    end
    return c;
  endfunction

  // Character i of the "END\r\n" trailer.
  function automatic logic [7:0] end_char(input logic [2:0] i);
    logic [7:0] c;
    case (i)
      3'd0:    c = 8'h45;
      3'd1:    c = 8'h4E;
      3'd2:    c = 8'h44;
      3'd3:    c = 8'h0D;
      3'd4:    c = 8'h0A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  assign rec_ready = (state_r == ST_IDLE);
  assign xfer_s    = tx_valid & tx_ready;
  assign busy      = (state_r != ST_IDLE) | pend_r;

  // END-pending flag: set by any dump_done pulse, cleared when the trailer's LF goes out.
  always_comb begin
    pend_s = pend_r;
    if (state_r == ST_ENDMSG && xfer_s && idx_r == END_LAST) begin
      pend_s = dump_done;
    end else if (dump_done) begin
      pend_s = 1'b1;
    end else begin
      pend_s = pend_r;
    end
  end

  // Main sequencer: record capture, byte indexing and registered tx outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      idx_r    <= 5'd0;
      pend_r   <= 1'b0;
      addr_r   <= 32'h0;
      data_r   <= 32'h0;
      rw_r     <= 1'b0;
      flags_r  <= 3'b000;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      pend_r <= pend_s;
      case (state_r)
        ST_IDLE: begin
          if (rec_valid) begin
            // a waiting record goes ahead of a pending END
            addr_r   <= rec_addr;
            data_r   <= rec_data;
            rw_r     <= rec_rw;
            flags_r  <= rec_flags;
            idx_r    <= 5'd0;
            state_r  <= ST_LINE;
            tx_valid <= 1'b1;
            tx_data  <= line_char(rec_addr, rec_data, rec_rw, rec_flags, 5'd0);
          end else if (pend_r) begin
            idx_r    <= 5'd0;
            state_r  <= ST_ENDMSG;
            tx_valid <= 1'b1;
            tx_data  <= end_char(3'd0);
          end else begin
            tx_valid <= 1'b0;
          end
        end
        ST_LINE: begin
          if (xfer_s) begin
            if (idx_r == LINE_LAST) begin
              idx_r <= 5'd0;
              if (pend_r || dump_done) begin
                state_r  <= ST_ENDMSG;
                tx_valid <= 1'b1;
                tx_data  <= end_char(3'd0);
              end else begin
                state_r  <= ST_IDLE;
                tx_valid <= 1'b0;
                tx_data  <= 8'h00;
              end
            end else begin
              idx_r   <= idx_r + 5'd1;
              tx_data <= line_char(addr_r, data_r, rw_r, flags_r, idx_r + 5'd1);
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        ST_ENDMSG: begin
          if (xfer_s) begin
            if (idx_r == END_LAST) begin
              idx_r    <= 5'd0;
              state_r  <= ST_IDLE;
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
            end else begin
              idx_r   <= idx_r + 5'd1;
              tx_data <= end_char(idx_r[2:0] + 3'd1);
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          idx_r    <= 5'd0;
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_record_formatter.sv
// Scoreboard bench for bus_record_formatter: stimulus pushes the expected
// ASCII bytes into a queue, a negedge monitor pops and compares every
// transferred byte and checks that tx_data holds steady while stalled.

module tb_bus_record_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rec_valid = 1'b0;
  logic        rec_ready;
  logic [31:0] rec_addr = 32'h0;
  logic [31:0] rec_data = 32'h0;
  logic        rec_rw = 1'b0;
  logic [2:0]  rec_flags = 3'b000;
  logic        dump_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;
  int pop_cnt = 0;
  int ready_mode = 0;
  logic [7:0] exp_q[$];

  bus_record_formatter dut (
    .clk(clk), .reset(reset), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_addr(rec_addr), .rec_data(rec_data), .rec_rw(rec_rw), .rec_flags(rec_flags),
    .dump_done(dump_done), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // tx_ready driver: always ready, or ready one cycle in three
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tx_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  // Monitor: compare transferred bytes against the scoreboard, check stall stability
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", {31'd0, tx_valid}, 32'd1);
          check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_byte: got 0x%02h expected none", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("byte", {24'd0, tx_data}, {24'd0, e});
          end
          pop_cnt++;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  task automatic send_rec(input logic [31:0] a, input logic [31:0] d, input logic rw,
                          input logic [2:0] fl, input logic dd);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (!rec_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rec_ready) begin
      total++;
      bad++;
      $display("FAIL rec_ready_timeout: got 0 expected 1");
    end
    rec_addr  = a;
    rec_data  = d;
    rec_rw    = rw;
    rec_flags = fl;
    rec_valid = 1'b1;
    dump_done = dd;
    @(posedge clk);
    #1;
    rec_valid = 1'b0;
    dump_done = 1'b0;
    // scramble the inputs; the line in progress must not notice
    rec_addr  = ~a;
    rec_data  = ~d;
    rec_rw    = ~rw;
    rec_flags = ~fl;
  endtask

  task automatic pulse_dump();
    @(posedge clk);
    #1;
    dump_done = 1'b1;
    @(posedge clk);
    #1;
    dump_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      if (!busy && !tx_valid && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ok_cnt;
    int gap;
    int rdy_gap;
    int base;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_rec_ready", {31'd0, rec_ready}, 32'd1);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // back-to-back line, rec_ready low throughout
    push_line("2020FFFF AAAAAAAA R7");
    send_rec(32'h2020FFFF, 32'hAAAAAAAA, 1'b1, 3'b111, 1'b0);
    ok_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (tx_valid && !rec_ready) ok_cnt++;
    end
    check("line1_consecutive", ok_cnt, 32'd22);
    @(negedge clk);
    check("line1_end_valid", {31'd0, tx_valid}, 32'd0);
    check("line1_end_ready", {31'd0, rec_ready}, 32'd1);
    wait_idle("line1_idle");

    // stalled line, tx_ready one cycle in three
    ready_mode = 1;
    push_line("12345678 55555555 W6");
    send_rec(32'h12345678, 32'h55555555, 1'b0, 3'b110, 1'b0);
    wait_idle("stall_idle");
    ready_mode = 0;

    // lone dump_done
    push_line("END");
    pulse_dump();
    check("end_busy_pending", {31'd0, busy}, 32'd1);
    wait_idle("end_idle");
    check("end_busy_after", {31'd0, busy}, 32'd0);

    // accept with dump_done together, second dump_done mid-line
    push_line("0000ABCD FFFF0000 R1");
    push_line("END");
    send_rec(32'h0000ABCD, 32'hFFFF0000, 1'b1, 3'b001, 1'b1);
    repeat (4) @(posedge clk);
    pulse_dump();
    wait_idle("dual_end_idle");
    repeat (10) @(posedge clk);

    // reset mid-line with a pending END discarded
    base = pop_cnt;
    push_line("FEDCBA98 76543210 W2");
    send_rec(32'hFEDCBA98, 32'h76543210, 1'b0, 3'b010, 1'b0);
    pulse_dump();
    for (int n = 0; n < 100 && pop_cnt < base + 10; n++) @(negedge clk);
    check("pre_reset_bytes", pop_cnt - base, 32'd10);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rec_ready", {31'd0, rec_ready}, 32'd1);
    push_line("00000001 00000000 R0");
    send_rec(32'h00000001, 32'h00000000, 1'b1, 3'b000, 1'b0);
    wait_idle("post_reset_idle");

    // back-to-back records with rec_valid held high
    push_line("DEADBEEF 0BADF00D W5");
    push_line("CAFE0000 89ABCDEF R3");
    @(posedge clk);
    #1;
    rec_addr  = 32'hDEADBEEF;
    rec_data  = 32'h0BADF00D;
    rec_rw    = 1'b0;
    rec_flags = 3'b101;
    rec_valid = 1'b1;
    @(posedge clk);
    #1;
    rec_addr  = 32'hCAFE0000;
    rec_data  = 32'h89ABCDEF;
    rec_rw    = 1'b1;
    rec_flags = 3'b011;
    gap = 0;
    rdy_gap = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!tx_valid) begin
        gap++;
        if (rec_ready) rdy_gap++;
      end else if (gap > 0) begin
        break;
      end
    end
    rec_valid = 1'b0;
    check("b2b_gap", gap, 32'd1);
    check("b2b_ready_in_gap", rdy_gap, 32'd1);
    wait_idle("b2b_idle");
    repeat (10) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
